// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side packer:
// packer FSM state encoding and a constant clog2 helper.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFlWait,
    StFlEmit,
    StDone
  } pack_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_pack_acc.sv
// Packing accumulator: PACK word slots filled in pop order plus a fill count.
// The packed view zero-fills every slot at or above the current count.
module sync_fifo_pack_acc import sync_fifo_pkg::*; #(
  parameter int unsigned BITWID  = 5,
  parameter int unsigned PACK    = 4,
  parameter int unsigned PACKWID = clog2(PACK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [BITWID-1:0]        cap_dat,
  input  logic                     clr,
  output logic [PACKWID:0]         acc_cnt,
  output logic [PACK*BITWID-1:0]   acc_dat
);

  localparam int unsigned CntW = PACKWID + 1;

  logic [BITWID-1:0] slot_q [PACK];
  logic [BITWID-1:0] slot_d [PACK];
  logic [PACKWID:0]  cnt_q, cnt_d;

  // Clear wins over capture; the two never coincide in normal operation.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cap_en) begin
      slot_d[cnt_q[PACKWID-1:0]] = cap_dat;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '{default: '0};
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  always_comb begin
    acc_dat = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CntW'(i) < cnt_q) acc_dat[i*BITWID +: BITWID] = slot_q[i];
    end
  end

  assign acc_cnt = cnt_q;

endmodule

// File: rtl/sync_fifo_packer.sv
// Read-side FIFO consumer: pops words against fifo_num, packs PACK of them into one
// output word on a valid/ready port, and drains a partial pack on flush.
module sync_fifo_packer import sync_fifo_pkg::*; #(
  parameter int unsigned DEEPWID = 3,
  parameter int unsigned BITWID  = 5,
  parameter int unsigned PACK    = 4,
  parameter int unsigned PACKWID = clog2(PACK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEEPWID:0]       fifo_num,
  output logic                   fifo_rd,
  input  logic [BITWID-1:0]      fifo_rd_dat,
  input  logic                   fifo_rd_dat_vld,
  input  logic                   flush,
  output logic [PACK*BITWID-1:0] out_dat,
  output logic [PACKWID:0]       out_cnt,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   flush_done,
  output logic                   proto_err
);

  localparam int unsigned CntW = PACKWID + 1;

  pack_state_e             state_q, state_d;
  logic                    pending_q, pending_d;
  logic [PACK*BITWID-1:0]  out_dat_q, out_dat_d;
  logic [PACKWID:0]        out_cnt_q, out_cnt_d;
  logic                    out_vld_q, out_vld_d;
  logic                    proto_err_q, proto_err_d;
  logic                    rst_q;

  logic [PACKWID:0]        acc_cnt;
  logic [PACK*BITWID-1:0]  acc_dat;
  logic                    out_free, drain_now, load, cap_en;

  sync_fifo_pack_acc #(
    .BITWID  (BITWID),
    .PACK    (PACK),
    .PACKWID (PACKWID)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (cap_en),
    .cap_dat (fifo_rd_dat),
    .clr     (load),
    .acc_cnt (acc_cnt),
    .acc_dat (acc_dat)
  );

  always_comb begin
    out_free  = !out_vld_q || out_rdy;
    drain_now = (state_q == StRun) && (acc_cnt == CntW'(PACK)) && out_free;
    // Pop purely from the occupancy count; the FIFO's empty flag depends on rd.
    fifo_rd   = !rst && (state_q == StRun) && (fifo_num != '0) &&
                (((32'(acc_cnt) + 32'(pending_q)) < PACK) || drain_now);
    // Data in the cycle right after reset belongs to a read that reset discarded.
    cap_en    = fifo_rd_dat_vld && pending_q;
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    pending_d   = fifo_rd;
    proto_err_d = proto_err_q || (fifo_rd_dat_vld && !pending_q && !rst_q);
    flush_done  = 1'b0;
    unique case (state_q)
      StRun: begin
        load = drain_now;
        if (flush) state_d = StFlWait;
      end
      StFlWait: begin
        if (!pending_q) state_d = (acc_cnt == '0) ? StDone : StFlEmit;
      end
      StFlEmit: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        flush_done = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase

    out_dat_d = out_dat_q;
    out_cnt_d = out_cnt_q;
    out_vld_d = out_vld_q && !out_rdy;
    if (load) begin
      out_dat_d = acc_dat;
      out_cnt_d = acc_cnt;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q     <= StRun;
      pending_q   <= 1'b0;
      out_dat_q   <= '0;
      out_cnt_q   <= '0;
      out_vld_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_dat_q   <= out_dat_d;
      out_cnt_q   <= out_cnt_d;
      out_vld_q   <= out_vld_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_dat   = out_dat_q;
  assign out_cnt   = out_cnt_q;
  assign out_vld   = out_vld_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sync_fifo_packer.sv
// Bench for sync_fifo_packer: a queue-based FIFO environment, a word-list packing
// model that predicts the output packet stream, directed cases and a random soak.
module tb_sync_fifo_packer;

  localparam int unsigned DEEPWID = 3;
  localparam int unsigned BITWID  = 5;
  localparam int unsigned PACK    = 4;
  localparam int unsigned PACKWID = 2;
  localparam int unsigned OW      = PACK * BITWID;
  localparam int unsigned CW      = PACKWID + 1;

  typedef struct packed {
    logic [OW-1:0] dat;
    logic [CW-1:0] cnt;
  } pkt_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DEEPWID:0]  fifo_num = '0;
  logic              fifo_rd;
  logic [BITWID-1:0] fifo_rd_dat = '0;
  logic              fifo_rd_dat_vld = 1'b0;
  logic              flush = 1'b0;
  logic [OW-1:0]     out_dat;
  logic [CW-1:0]     out_cnt;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic              flush_done;
  logic              proto_err;

  sync_fifo_packer #(
    .DEEPWID (DEEPWID),
    .BITWID  (BITWID),
    .PACK    (PACK),
    .PACKWID (PACKWID)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_num        (fifo_num),
    .fifo_rd         (fifo_rd),
    .fifo_rd_dat     (fifo_rd_dat),
    .fifo_rd_dat_vld (fifo_rd_dat_vld),
    .flush           (flush),
    .out_dat         (out_dat),
    .out_cnt         (out_cnt),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .flush_done      (flush_done),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [BITWID-1:0] fifo_q[$];
  logic [BITWID-1:0] part_q[$];
  pkt_t              exp_q[$];
  pkt_t              got_q[$];

  int   cyc = 0;
  int   first_rd_cyc = -1;
  int   first_vld_cyc = -1;
  int   fd_expect = 0;
  int   fd_seen = 0;
  bit   flush_busy = 1'b0;
  bit   perr_m = 1'b0;
  bit   rd_prev = 1'b0;
  bit   rst_prev = 1'b0;
  bit   force_vld = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Words popped since the last packet boundary become one packet.
  task automatic cut_part();
    pkt_t p;
    p.dat = '0;
    p.cnt = CW'(part_q.size());
    foreach (part_q[i]) p.dat = p.dat + (OW'(part_q[i]) << (BITWID * i));
    if (part_q.size() > 0) exp_q.push_back(p);
    part_q.delete();
  endtask

  // Monitor/model at negedge, FIFO environment shortly after posedge.
  initial begin : mon
    pkt_t g;
    forever begin
      @(negedge clk);
      cyc++;
      check("proto_err", proto_err, perr_m);
      check("rd_when_empty", fifo_rd && (fifo_num == '0), 0);
      if (rst) begin
        check("rd_in_rst", fifo_rd, 0);
        exp_q.delete();
        part_q.delete();
        fd_expect  = 0;
        flush_busy = 1'b0;
        perr_m     = 1'b0;
      end else begin
        if (fifo_rd_dat_vld && !rd_prev && !rst_prev) perr_m = 1'b1;
        if (flush_done) begin
          check("flush_done_spurious", fd_expect == 0, 0);
          if (fd_expect > 0) fd_expect--;
          flush_busy = 1'b0;
          fd_seen++;
        end
        if (out_vld) begin
          if (first_vld_cyc < 0) first_vld_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("out_extra", out_vld, 0);
          end else begin
            check("out_dat", out_dat, exp_q[0].dat);
            check("out_cnt", out_cnt, exp_q[0].cnt);
            if (out_rdy) void'(exp_q.pop_front());
          end
          if (out_rdy) begin
            g.dat = out_dat;
            g.cnt = out_cnt;
            got_q.push_back(g);
          end
        end
        if (fifo_rd && fifo_q.size() > 0) begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          part_q.push_back(fifo_q[0]);
          if (part_q.size() == PACK) cut_part();
        end
        if (flush) begin
          cut_part();
          fd_expect++;
          flush_busy = 1'b1;
        end
      end
      rd_prev  = fifo_rd;
      rst_prev = rst;

      @(posedge clk);
      #2;
      if (rd_prev && fifo_q.size() > 0) begin
        fifo_rd_dat     = fifo_q.pop_front();
        fifo_rd_dat_vld = 1'b1;
      end else if (force_vld) begin
        fifo_rd_dat     = 5'h1F;
        fifo_rd_dat_vld = 1'b1;
      end else begin
        fifo_rd_dat     = BITWID'($urandom);
        fifo_rd_dat_vld = 1'b0;
      end
      fifo_num = (DEEPWID + 1)'(fifo_q.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(BITWID'(first + i));
  endtask

  task automatic wait_drained(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (fifo_q.size() == 0 && !rd_prev && !fifo_rd_dat_vld && !out_vld &&
          exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
    tick();
  endtask

  task automatic wait_flush_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (flush_done) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int base, fd0;
    bit vld_seen;

    // Reset state
    repeat (3) tick();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_dat", out_dat, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_proto_err", proto_err, 0);
    rst = 1'b0;
    tick();

    // Streaming 1..8 with ready high
    out_rdy = 1'b1;
    base = got_q.size();
    push_words(1, 8);
    wait_drained("t1_drain");
    check("t1_npkts", got_q.size() - base, 2);
    if (got_q.size() >= base + 2) begin
      check("t1_pkt0_dat", got_q[base].dat, 20'h20C41);
      check("t1_pkt0_cnt", got_q[base].cnt, 4);
      check("t1_pkt1_dat", got_q[base+1].dat, 20'h41CC5);
      check("t1_pkt1_cnt", got_q[base+1].cnt, 4);
    end
    check("t1_latency", first_vld_cyc - first_rd_cyc, 6);

    // Backpressure with 12 words
    out_rdy = 1'b0;
    base = got_q.size();
    push_words(1, 12);
    repeat (20) tick();
    check("t2_rd_stalled", fifo_rd, 0);
    check("t2_fifo_num", fifo_num, 4);
    check("t2_out_vld", out_vld, 1);
    check("t2_out_dat", out_dat, 20'h20C41);
    repeat (5) tick();
    check("t2_out_dat_hold", out_dat, 20'h20C41);
    out_rdy = 1'b1;
    wait_drained("t2_drain");
    check("t2_npkts", got_q.size() - base, 3);
    if (got_q.size() >= base + 3) begin
      check("t2_pkt1_dat", got_q[base+1].dat, 20'h41CC5);
      check("t2_pkt2_dat", got_q[base+2].dat, 20'h62D49);
    end

    // Partial pack of 1,2,3 then flush
    push_words(1, 3);
    wait_drained("t3_drain");
    fd0 = fd_seen;
    pulse_flush();
    wait_flush_done("t3_flush_done");
    check("t3_out_vld", out_vld, 1);
    check("t3_out_cnt", out_cnt, 3);
    check("t3_out_dat", out_dat, 20'h00C41);
    repeat (5) tick();
    check("t3_one_pulse", fd_seen - fd0, 1);

    // Flush with empty accumulator
    fd0 = fd_seen;
    vld_seen = 1'b0;
    pulse_flush();
    for (int i = 0; i < 10; i++) begin
      if (out_vld) vld_seen = 1'b1;
      tick();
    end
    check("t4_pulse", fd_seen - fd0, 1);
    check("t4_no_out", vld_seen, 0);

    // Flush in the same cycle as a pop
    push_words(5, 2);
    wait_drained("t5_drain");
    fifo_q.push_back(BITWID'(7));
    flush = 1'b1;
    #2;
    check("t5_rd_with_flush", fifo_rd, 1);
    tick();
    flush = 1'b0;
    wait_flush_done("t5_flush_done");
    check("t5_out_cnt", out_cnt, 3);
    check("t5_out_dat", out_dat, 20'h01CC5);
    repeat (3) tick();

    // Read data with no read outstanding
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    repeat (3) tick();
    check("t6_proto_err", proto_err, 1);
    base = got_q.size();
    push_words(21, 4);
    wait_drained("t6_drain");
    check("t6_npkts", got_q.size() - base, 1);
    if (got_q.size() >= base + 1) check("t6_pkt_dat", got_q[base].dat, 20'hC5ED5);
    check("t6_proto_sticky", proto_err, 1);

    // Reset mid-pack with output held
    out_rdy = 1'b0;
    push_words(1, 6);
    repeat (20) tick();
    check("t7_pre_vld", out_vld, 1);
    rst = 1'b1;
    tick();
    check("t7_out_vld", out_vld, 0);
    check("t7_out_cnt", out_cnt, 0);
    check("t7_out_dat", out_dat, 0);
    check("t7_flush_done", flush_done, 0);
    check("t7_proto_err", proto_err, 0);
    check("t7_fifo_rd", fifo_rd, 0);
    rst = 1'b0;
    out_rdy = 1'b1;
    tick();
    base = got_q.size();
    push_words(1, 4);
    wait_drained("t7_drain");
    check("t7_npkts", got_q.size() - base, 1);
    if (got_q.size() >= base + 1) begin
      check("t7_pkt_dat", got_q[base].dat, 20'h20C41);
      check("t7_pkt_cnt", got_q[base].cnt, 4);
    end

    // Random soak
    for (int c = 0; c < 1500; c++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) fifo_q.push_back(BITWID'($urandom));
      out_rdy = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 300) == 0);
      flush   = !rst && !flush_busy && ($urandom_range(0, 40) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    out_rdy = 1'b1;
    wait_drained("rand_drain");
    for (int i = 0; i < 40 && flush_busy; i++) tick();
    pulse_flush();
    wait_flush_done("rand_flush_done");
    wait_drained("rand_final_drain");
    check("rand_exp_empty", exp_q.size(), 0);
    check("rand_part_empty", part_q.size(), 0);
    check("rand_fd_pending", fd_expect, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_packer.md
Name: sync_fifo_packer

Overview:
Read-side consumer of the team's synchronous FIFO. It pops BITWID-bit words using the FIFO's `fifo_num` count and its 1-cycle registered read data (`rd_dat` plus `rd_dat_vld` one cycle after `rd`). It packs PACK consecutive words into one wide word and presents it downstream on a valid/ready handshake. A flush command drains a partially filled pack.

Parameters:
- DEEPWID, 3, FIFO address width; `fifo_num` is DEEPWID+1 bits.
- BITWID, 5, width of one FIFO word.
- PACK, 4, FIFO words per output word; must be ≥2.
- PACKWID, 2, clog2(PACK); `out_cnt` is PACKWID+1 bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- fifo_num  in  DEEPWID+1  FIFO occupancy.
- fifo_rd  out  1  pop request to FIFO `rd`.
- fifo_rd_dat  in  BITWID  FIFO `rd_dat`.
- fifo_rd_dat_vld  in  1  FIFO `rd_dat_vld`.
- flush  in  1  single-cycle request to emit the partial pack.
- out_dat  out  PACK*BITWID  packed word; first-popped word in bits [BITWID-1:0].
- out_cnt  out  PACKWID+1  number of valid words in `out_dat` (1..PACK).
- out_vld  out  1  output valid.
- out_rdy  in  1  downstream ready.
- flush_done  out  1  one-cycle pulse when a flush completes.
- proto_err  out  1  sticky: read data arrived with no read outstanding.

Behaviour:
- Reset: one clock and a single synchronous active-high reset, as decided.
  - `rst`=1 at a rising edge clears all state: `out_dat`=0, `out_cnt`=0, `out_vld`=0, `flush_done`=0, `proto_err`=0, accumulator count `acc_cnt`=0, `pending`=0, state=RUN.
  - `fifo_rd` is forced 0 while `rst`=1.
  - Reset mid-pack discards the accumulator and any in-flight read. Read data returning in the cycle after reset is ignored and does not set `proto_err`.
- Internal state:
  - Accumulator: PACK slots plus `acc_cnt` (0..PACK).
  - `pending`: registered copy of `fifo_rd`, i.e. one read in flight.
  - Output register: `out_dat`/`out_cnt`/`out_vld`.
- Pop rule (combinational):
  - `fifo_rd` = state==RUN && `fifo_num`!=0 && (`acc_cnt`+`pending` < PACK || `drain_now`).
  - `fifo_rd` never depends on the FIFO's `empty`/`full` outputs. Those outputs are combinational in `rd`, so using them would create a combinational loop.
  - Because the FIFO pointers update on the `rd` edge, `fifo_num` is exact every cycle, and the block never pops an empty FIFO.
- Capture:
  - When `fifo_rd_dat_vld`=1 and `pending`=1: write `fifo_rd_dat` into slot `acc_cnt` and increment `acc_cnt`.
  - When `fifo_rd_dat_vld`=1 and `pending`=0: set `proto_err` and discard the data.
- Drain:
  - `out_free` = !`out_vld` || `out_rdy`.
  - `drain_now` = `acc_cnt`==PACK && `out_free`.
  - On `drain_now`, the next cycle has `out_vld`=1, `out_cnt`=PACK, `out_dat`=accumulator, and `acc_cnt` cleared.
  - `drain_now` implies `pending`=0, so no capture collides with it.
  - Streaming throughput: PACK words per PACK+1 cycles. Latency: first `fifo_rd` at cycle 0 gives `out_vld`=1 at cycle PACK+2.
- Output handshake:
  - `out_vld` && `out_rdy` completes a transfer.
  - `out_dat`/`out_cnt` stay stable while `out_vld`=1 and `out_rdy`=0.
  - `out_vld` falls after a transfer unless a new drain loads in the same cycle (back-to-back transfers are allowed).
- FSM:
  - RUN: normal operation. `flush`=1 → FL_WAIT; no new `fifo_rd` is issued from that cycle onward.
  - FL_WAIT: wait for `pending`=0 (the in-flight word is captured).
    - `acc_cnt`==0 → DONE.
    - Otherwise → FL_EMIT.
  - FL_EMIT: when `out_free`, load the output register with `out_cnt`=`acc_cnt`; unused high slots are zero; clear `acc_cnt` → DONE.
    - If `acc_cnt`==PACK, a normal full emit is used.
  - DONE: `flush_done`=1 for one cycle → RUN.
- `flush` outside RUN is ignored.
- FIFO data left after a flush is popped normally in RUN.

Decomposition:
- Shared package (`sync_fifo_pkg`): FSM state encoding (RUN, FL_WAIT, FL_EMIT, DONE) and the PACKWID/clog2 helper, shared with the FIFO's DEEPWID derivation.
- One natural sub-module: `sync_fifo_pack_acc` (slot array, `acc_cnt`, zero-fill). The FSM, pop logic and output register stay in the top module.

Test Plan:
- FIFO preloaded with 1..8, `out_rdy`=1:
  - `out_dat`=0x20C41 then 0x41CC5, both with `out_cnt`=4.
  - First `out_vld` 6 cycles after first `fifo_rd`; `fifo_rd` never high with `fifo_num`=0.
- 12 words, `out_rdy`=0:
  - After 8 pops `fifo_rd` stays 0, `fifo_num`=4, and `out_dat` holds 0x20C41 stable.
  - Raise `out_rdy` → remaining packets in order, no loss or duplication.
- Words 1,2,3 then `flush`:
  - Single output `out_cnt`=3, `out_dat`=0x00C41.
  - `flush_done` pulses once after the emit cycle.
- `flush` with an empty accumulator and `pending`=0: `flush_done` pulse, no `out_vld`.
- `flush` asserted in the same cycle as `fifo_rd`: the in-flight word is captured and included in the partial pack (`out_cnt`=`acc_cnt`+1).
- `fifo_rd_dat_vld` forced with no read outstanding: `proto_err`=1 and stays 1; `acc_cnt` unchanged.
- `rst` pulsed mid-pack (`acc_cnt`=2, `out_vld`=1):
  - Next cycle all outputs are 0.
  - A fresh 4-word stream then packs correctly from slot 0.
